dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single 256-bit off-chip data memory port between two cache-line clients (requester 0 = data cache miss/write-back path, requester 1 = instruction cache or second client). Each client side is a copy of the memory interface the caches already drive: enable/write/address/line data out, line data/ack in. Arbitration is round-robin with the grant held for one full memory transaction. A watchdog flags a memory that fails to acknowledge.

## Interface
- TIMEOUT, 64: cycles in BUSY without mem_ack_i before err_o sets (≥2).
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- m0_enable_i / m1_enable_i  in  1  request; held high until that requester's ack.
- m0_write_i / m1_write_i  in  1  1 = line write, 0 = line read.
- m0_addr_i / m1_addr_i  in  32  line address (low 5 bits zero).
- m0_data_i / m1_data_i  in  256  write line data.
- m0_data_o / m1_data_o  out  256  read line data (both = mem_data_i).
- m0_ack_o / m1_ack_o  out  1  transaction-complete pulse for that requester.
- mem_enable_o  out  1  to memory.
- mem_write_o  out  1  to memory.
- mem_addr_o  out  32  to memory.
- mem_data_o  out  256  to memory.
- mem_data_i  in  256  from memory.
- mem_ack_i  in  1  from memory, one-cycle pulse.
- grant_o  out  1  index of current/last granted requester.
- busy_o  out  1  high in BUSY.
- err_o  out  1  sticky watchdog error.

## Operation
- States: IDLE, BUSY. Registers: state, grant (1 bit), last (1 bit, last served), wdog counter (clog2(TIMEOUT+1) bits), err.
- IDLE: if no request, stay. If exactly one mN_enable_i high, grant ← N, → BUSY. If both high, grant ← ~last, → BUSY.
- BUSY: mem_enable_o = 1; mem_write_o/mem_addr_o/mem_data_o = combinational mux of granted requester's inputs. On mem_ack_i: m{grant}_ack_o = 1 same cycle, last ← grant, → IDLE.
- Non-granted ack output is always 0; mem_ack_i outside BUSY is ignored (no ack forwarded).
- In IDLE: mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
- Requester dropping enable while granted: no abort; arbiter stays BUSY until mem_ack_i (memory transaction already committed); ack still pulsed.
- A requester keeping enable high after its ack (e.g. write-back followed by refill) is treated as a new request in the next IDLE cycle and competes normally; round-robin gives the other requester priority if both are pending.
- Watchdog: wdog clears on entry to BUSY, increments each BUSY cycle without ack, saturates at TIMEOUT; reaching TIMEOUT sets err. err clears only on reset. Arbiter keeps waiting (no forced release).
- grant_o = grant register; busy_o = (state == BUSY).

## Timing
- Reset (async, immediate): state IDLE, grant 0, last 1 (requester 0 wins first tie), wdog 0, err 0; all outputs 0 except mN_data_o = mem_data_i.
- Request seen high in IDLE at cycle t → mem_enable_o high from t+1.
- mem_ack_i at cycle a → mN_ack_o high in cycle a (combinational), mem_enable_o low at a+1 (IDLE), next grant earliest at a+2 → mem_enable_o back high at a+2. Guaranteed ≥1 cycle of mem_enable_o low between transactions so the memory restarts its latency count.
- Requester must sample mN_data_o in the cycle mN_ack_o is high.
- Reset asserted mid-BUSY: mem_enable_o drops immediately, no ack emitted; requesters are reset in the same domain.
- err_o rises on the edge where wdog reaches TIMEOUT (TIMEOUT BUSY cycles after grant with no ack).

## Test plan
- Single read, memory ack latency 10: m0 read addr 0x0000_0400 at t=2 → mem_enable_o 1 at t=3, mem_addr_o 0x400, mem_write_o 0, m0_ack_o at t=13 with line data, m1_ack_o 0, back to IDLE t=14.
- Simultaneous requests after reset: m0 write 0x20, m1 read 0x40 both at t=2 → m0 served first (mem_write_o 1, data = m0_data_i), then mem_enable_o low one cycle, m1 served; grant_o 0 then 1.
- Round-robin fairness: m0 and m1 held permanently requesting for 6 transactions → grants alternate 0,1,0,1,0,1; no back-to-back same-requester grant.
- Write-back then refill on m0 (enable held, write 1→0 at ack) while m1 idle → two m0 transactions separated by exactly one idle cycle; second has mem_write_o 0.
- Watchdog: TIMEOUT=8, memory never acks → err_o rises 8 cycles after mem_enable_o rises, stays high, arbiter remains BUSY; async reset clears err_o and mem_enable_o at once.
- Stray ack: mem_ack_i pulsed in IDLE → no mN_ack_o, state unchanged; m1 drops enable mid-BUSY → still receives m1_ack_o at memory ack.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one 256-bit line memory port between two cache clients
module dmem_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         m0_enable_i,
   input  logic         m0_write_i,
   input  logic [31:0]  m0_addr_i,
   input  logic [255:0] m0_data_i,
   output logic [255:0] m0_data_o,
   output logic         m0_ack_o,
   input  logic         m1_enable_i,
   input  logic         m1_write_i,
   input  logic [31:0]  m1_addr_i,
   input  logic [255:0] m1_data_i,
   output logic [255:0] m1_data_o,
   output logic         m1_ack_o,
   output logic         mem_enable_o,
   output logic         mem_write_o,
   output logic [31:0]  mem_addr_o,
   output logic [255:0] mem_data_o,
   input  logic [255:0] mem_data_i,
   input  logic         mem_ack_i,
   output logic         grant_o,
   output logic         busy_o,
   output logic         err_o
);

   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WDOG_MAX = WDW'(TIMEOUT);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic           grant_q, grant_d;
   logic           last_q, last_d;
   logic           err_q, err_d;
   logic [WDW-1:0] wdog_q, wdog_d;

   // Read data is broadcast; only the acked requester samples it.
   assign m0_data_o = mem_data_i;
   assign m1_data_o = mem_data_i;
   assign grant_o   = grant_q;
   assign busy_o    = (state_q == BUSY);
   assign err_o     = err_q;

   // State register; last starts at 1 so requester 0 wins the first tie.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         wdog_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
         err_q   <= err_d;
      end
   end

   // Arbitration, memory-port mux, ack routing and watchdog.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_d       = last_q;
      wdog_d       = wdog_q;
      err_d        = err_q;
      m0_ack_o     = 1'b0;
      m1_ack_o     = 1'b0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      case (state_q)
         IDLE: begin
            // A stray mem_ack_i here is deliberately ignored.
            if (m0_enable_i || m1_enable_i) begin
               state_d = BUSY;
               wdog_d  = '0;
               if (m0_enable_i && m1_enable_i) begin
                  grant_d = ~last_q;
               end else begin
                  grant_d = m1_enable_i;
               end
            end
         end
         BUSY: begin
            // The transaction is committed: enable drops from the client do not abort it.
            mem_enable_o = 1'b1;
            mem_write_o  = grant_q ? m1_write_i : m0_write_i;
            mem_addr_o   = grant_q ? m1_addr_i  : m0_addr_i;
            mem_data_o   = grant_q ? m1_data_i  : m0_data_i;
            if (mem_ack_i) begin
               m0_ack_o = ~grant_q;
               m1_ack_o = grant_q;
               last_d   = grant_q;
               state_d  = IDLE;
            end else begin
               if (wdog_q != WDOG_MAX) begin
                  wdog_d = wdog_q + 1'b1;
               end
               if (wdog_d == WDOG_MAX) begin
                  err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   localparam int TO = 8;
   localparam int NEVER = 100000;

   logic         clk;
   logic         rst;
   logic         en [2];
   logic         wr [2];
   logic [31:0]  addr [2];
   logic [255:0] wdata [2];
   logic [255:0] mem_rdata;
   logic         mem_ack;
   logic         stray;

   logic [255:0] m0_data_o, m1_data_o, mem_data_o;
   logic         m0_ack_o, m1_ack_o, mem_enable_o, mem_write_o;
   logic [31:0]  mem_addr_o;
   logic         grant_o, busy_o, err_o;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the port, who was served last, how long the
   // memory has been silent, and the list of served requesters in order.
   bit m_busy;
   int m_grant;
   int m_last;
   int m_wait;
   bit m_err;
   int bcnt;
   int lat;
   int lat_mode;
   bit ev_ack [2];
   int served [$];
   int tcount;
   logic obs_en, obs_err;

   dmem_arbiter #(.TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_enable_i(en[0]), .m0_write_i(wr[0]), .m0_addr_i(addr[0]), .m0_data_i(wdata[0]),
      .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
      .m1_enable_i(en[1]), .m1_write_i(wr[1]), .m1_addr_i(addr[1]), .m1_data_i(wdata[1]),
      .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
      .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (t=%0d)", tag, got, exp, tcount);
      end
   endtask

   task automatic new_req(input int i, input logic w);
      en[i]    = 1'b1;
      wr[i]    = w;
      addr[i]  = {$urandom(), 5'b0} & 32'hFFFF_FFE0;
      wdata[i] = {8{$urandom()}};
   endtask

   task automatic model_reset();
      m_busy  = 0;
      m_grant = 0;
      m_last  = 1;
      m_wait  = 0;
      m_err   = 0;
      bcnt    = 0;
      served.delete();
   endtask

   task automatic model_step();
      ev_ack[0] = 0;
      ev_ack[1] = 0;
      if (m_busy) begin
         if (mem_ack) begin
            ev_ack[m_grant] = 1;
            served.push_back(m_grant);
            m_last = m_grant;
            m_busy = 0;
         end else begin
            if (m_wait < TO) m_wait++;
            if (m_wait == TO) m_err = 1;
            bcnt++;
         end
      end else if (en[0] || en[1]) begin
         m_grant = (en[0] && en[1]) ? 1 - m_last : (en[1] ? 1 : 0);
         m_busy  = 1;
         m_wait  = 0;
         bcnt    = 0;
         lat     = (lat_mode < 0) ? int'($urandom_range(0, 5)) : lat_mode;
      end
   endtask

   // One clock: drive memory response, compare at the falling edge, advance model.
   task automatic tick();
      logic [255:0] e_data;
      logic [31:0]  e_addr;
      logic         e_wr;
      mem_ack   = m_busy ? (bcnt == lat) : stray;
      mem_rdata = {8{$urandom()}};
      @(negedge clk);
      e_wr   = m_busy ? wr[m_grant] : 1'b0;
      e_addr = m_busy ? addr[m_grant] : 32'h0;
      e_data = m_busy ? wdata[m_grant] : 256'h0;
      check("busy", busy_o, m_busy);
      check("mem_enable", mem_enable_o, m_busy);
      check("mem_write", mem_write_o, e_wr);
      check("mem_addr", mem_addr_o, e_addr);
      check("mem_data", mem_data_o, e_data);
      check("m0_ack", m0_ack_o, m_busy && mem_ack && m_grant == 0);
      check("m1_ack", m1_ack_o, m_busy && mem_ack && m_grant == 1);
      check("m0_rdata", m0_data_o, mem_rdata);
      check("m1_rdata", m1_data_o, mem_rdata);
      check("grant", grant_o, m_grant[0]);
      check("err", err_o, m_err);
      obs_en  = mem_enable_o;
      obs_err = err_o;
      model_step();
      @(posedge clk);
      #1;
      stray   = 1'b0;
      mem_ack = 1'b0;
      tcount++;
   endtask

   // Asynchronous reset applied away from any edge; outputs must clear at once.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_enable", mem_enable_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_err", err_o, 1'b0);
      check("rst_grant", grant_o, 1'b0);
      check("rst_ack", {m0_ack_o, m1_ack_o}, 2'b00);
      for (int i = 0; i < 2; i++) begin
         en[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      end
      mem_ack = 1'b0;
      stray   = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst    = 1'b0;
      tcount = 0;
   endtask

   initial begin
      int ack_t, en_t, err_t, gap;
      bit got;
      rst = 1'b1;
      lat_mode = 0;
      mem_rdata = '0;
      for (int i = 0; i < 2; i++) begin
         en[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      end
      mem_ack = 1'b0;
      stray = 1'b0;
      tcount = 0;
      @(posedge clk);
      #1;
      do_reset();

      // Single read with ack latency 10.
      tick(); tick();
      en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0000_0400; wdata[0] = {8{$urandom()}};
      lat_mode = 10;
      ack_t = -1; en_t = -1;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (obs_en && en_t < 0) en_t = tcount - 1;
         if (ev_ack[0]) begin ack_t = tcount - 1; en[0] = 1'b0; break; end
      end
      check("rd_enable_t", en_t, 3);
      check("rd_ack_t", ack_t, 13);
      tick();
      check("rd_idle_after", obs_en, 1'b0);

      // Simultaneous requests after reset: m0 first, then m1.
      do_reset();
      lat_mode = 3;
      tick(); tick();
      en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h20; wdata[0] = {8{$urandom()}};
      en[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h40; wdata[1] = {8{$urandom()}};
      for (int k = 0; k < 40 && served.size() < 2; k++) begin
         tick();
         for (int i = 0; i < 2; i++) if (ev_ack[i]) en[i] = 1'b0;
      end
      check("sim_count", served.size(), 2);
      if (served.size() == 2) check("sim_order", {served[0][0], served[1][0]}, 2'b01);

      // Fairness with both permanently requesting.
      do_reset();
      lat_mode = -1;
      new_req(0, $urandom_range(0, 1));
      new_req(1, $urandom_range(0, 1));
      for (int k = 0; k < 100 && served.size() < 6; k++) begin
         tick();
         for (int i = 0; i < 2; i++) if (ev_ack[i]) new_req(i, $urandom_range(0, 1));
      end
      check("rr_count", served.size(), 6);
      for (int i = 0; i < served.size(); i++) check("rr_order", served[i], i % 2);

      // Write-back then refill on m0 with enable held.
      do_reset();
      lat_mode = 2;
      en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h1000; wdata[0] = {8{$urandom()}};
      got = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (ev_ack[0]) begin got = 1; wr[0] = 1'b0; addr[0] = 32'h2000; break; end
      end
      check("wb_first_ack", got, 1'b1);
      gap = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (obs_en) break;
         gap++;
      end
      check("wb_gap", gap, 1);
      got = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (ev_ack[0]) begin got = 1; en[0] = 1'b0; break; end
      end
      check("wb_refill_ack", got, 1'b1);

      // Watchdog: memory never answers.
      do_reset();
      lat_mode = NEVER;
      new_req(1, 1'b1);
      en_t = -1; err_t = -1;
      for (int k = 0; k < 16; k++) begin
         tick();
         if (obs_en && en_t < 0) en_t = tcount - 1;
         if (obs_err && err_t < 0) err_t = tcount - 1;
      end
      check("wdog_delay", err_t - en_t, TO);
      check("wdog_still_busy", busy_o, 1'b1);
      do_reset();

      // Stray ack in IDLE, then m1 drops enable while granted.
      lat_mode = 4;
      tick();
      stray = 1'b1;
      tick();
      new_req(1, 1'b0);
      tick();
      en[1] = 1'b0;
      got = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (ev_ack[1]) begin got = 1; break; end
      end
      check("drop_still_acked", got, 1'b1);

      // Randomized traffic.
      do_reset();
      lat_mode = -1;
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < 2; i++)
            if (!en[i] && $urandom_range(0, 3) == 0) new_req(i, $urandom_range(0, 1));
         stray = !m_busy && $urandom_range(0, 9) == 0;
         tick();
         for (int i = 0; i < 2; i++)
            if (ev_ack[i]) begin
               if ($urandom_range(0, 1) == 1) new_req(i, $urandom_range(0, 1));
               else en[i] = 1'b0;
            end
         if (m_busy && en[m_grant] && $urandom_range(0, 19) == 0) en[m_grant] = 1'b0;
      end
      for (int i = 1; i < served.size(); i++) ;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
